// File: rtl/fft16_seq.sv
// Sequencer for a 16-point radix-4 FFT on a 16-bit peripheral bus.
// Holds the sample buffer and steers operands through an external butterfly.
module fft16_seq #(
    parameter logic [13:0] BASE_ADDR = 14'h0088
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    output logic [15:0] per_dout,
    output logic [15:0] bf_ar,
    output logic [15:0] bf_ai,
    output logic [15:0] bf_br,
    output logic [15:0] bf_bi,
    output logic [15:0] bf_cr,
    output logic [15:0] bf_ci,
    output logic [15:0] bf_dr,
    output logic [15:0] bf_di,
    input  logic [15:0] bf_0r,
    input  logic [15:0] bf_0i,
    input  logic [15:0] bf_1r,
    input  logic [15:0] bf_1i,
    input  logic [15:0] bf_2r,
    input  logic [15:0] bf_2i,
    input  logic [15:0] bf_3r,
    input  logic [15:0] bf_3i,
    output logic        bf_stage,
    output logic [1:0]  bf_grp,
    output logic        bf_valid,
    output logic        fft_irq
);

    typedef enum logic [1:0] {IDLE, S1, S2, FIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grp_q, grp_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        irq_q, irq_d;
    logic [15:0] re_q [16];
    logic [15:0] re_d [16];
    logic [15:0] im_q [16];
    logic [15:0] im_d [16];

    logic [13:0] off;
    logic        hit, wr, rd, busy, act, s2;
    logic [3:0]  rev;
    logic [3:0]  idx [4];

    assign off  = per_addr - BASE_ADDR;
    assign hit  = per_en && (off[13:2] == 12'h000);
    assign wr   = hit && (per_we != 2'b00);
    assign rd   = hit && (per_we == 2'b00);
    assign busy = (state_q != IDLE);
    assign s2   = (state_q == S2);
    assign act  = (state_q == S1) || s2;
    assign rev  = {ptr_q[1:0], ptr_q[3:2]};

    // Stage 1 strides by 4 across the buffer; stage 2 works on contiguous quads.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            idx[n] = s2 ? {grp_q, 2'(n)} : {2'(n), grp_q};
        end
    end

    assign bf_ar    = act ? re_q[idx[0]] : 16'h0;
    assign bf_ai    = act ? im_q[idx[0]] : 16'h0;
    assign bf_br    = act ? re_q[idx[1]] : 16'h0;
    assign bf_bi    = act ? im_q[idx[1]] : 16'h0;
    assign bf_cr    = act ? re_q[idx[2]] : 16'h0;
    assign bf_ci    = act ? im_q[idx[2]] : 16'h0;
    assign bf_dr    = act ? re_q[idx[3]] : 16'h0;
    assign bf_di    = act ? im_q[idx[3]] : 16'h0;
    assign bf_valid = act;
    assign bf_stage = act && s2;
    assign bf_grp   = act ? grp_q : 2'd0;
    assign fft_irq  = irq_q;

    always_comb begin
        per_dout = 16'h0;
        if (rd) begin
            unique case (off[1:0])
                2'd0: per_dout = {13'b0, err_q, done_q, busy};
                2'd1: per_dout = {12'b0, ptr_q};
                2'd2: per_dout = re_q[rev];
                2'd3: per_dout = im_q[rev];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        ptr_d   = ptr_q;
        done_d  = done_q;
        err_d   = err_q;
        irq_d   = 1'b0;
        re_d    = re_q;
        im_d    = im_q;
        if (wr && off[1:0] == 2'd0 && per_din[1]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            ptr_d  = 4'd0;
        end
        unique case (state_q)
            IDLE: begin
                if (wr) begin
                    unique case (off[1:0])
                        2'd0: begin
                            if (per_din[0]) begin
                                state_d = S1;
                                grp_d   = 2'd0;
                                done_d  = 1'b0;
                            end
                        end
                        2'd1: ptr_d = per_din[3:0];
                        2'd2: re_d[ptr_q] = per_din;
                        2'd3: begin
                            im_d[ptr_q] = per_din;
                            ptr_d       = ptr_q + 4'd1;
                        end
                    endcase
                end else if (rd && off[1:0] == 2'd3) begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            S1, S2: begin
                if (wr && (off[1:0] != 2'd0 || per_din[0])) begin
                    err_d = 1'b1;
                end
                re_d[idx[0]] = bf_0r;
                im_d[idx[0]] = bf_0i;
                re_d[idx[1]] = bf_1r;
                im_d[idx[1]] = bf_1i;
                re_d[idx[2]] = bf_2r;
                im_d[idx[2]] = bf_2i;
                re_d[idx[3]] = bf_3r;
                im_d[idx[3]] = bf_3i;
                grp_d        = grp_q + 2'd1;
                if (grp_q == 2'd3) begin
                    state_d = s2 ? FIN : S2;
                end
            end
            FIN: begin
                if (wr && (off[1:0] != 2'd0 || per_din[0])) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
                done_d  = 1'b1;
                irq_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= IDLE;
            grp_q   <= 2'd0;
            ptr_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                re_q[i] <= 16'h0;
                im_q[i] <= 16'h0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

endmodule
